// File: rtl/conv3x3_pkg.sv
// Shared definitions for the 3x3 window engine: kernel select codes,
// controller states and default frame geometry.
package conv3x3_pkg;

  localparam logic [1:0] MODE_PASS    = 2'b00;
  localparam logic [1:0] MODE_GAUSS   = 2'b01;
  localparam logic [1:0] MODE_LAPLACE = 2'b10;
  localparam logic [1:0] MODE_SHARPEN = 2'b11;

  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv3x3_kernel.sv
// Two-stage 3x3 kernel datapath: stage A forms the weighted sum for the
// selected kernel, stage B normalises/rectifies/clamps to a pixel.
module conv3x3_kernel
  import conv3x3_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  input  logic [DATA_W-1:0] p4,
  input  logic [DATA_W-1:0] p5,
  input  logic [DATA_W-1:0] p6,
  input  logic [DATA_W-1:0] p7,
  input  logic [DATA_W-1:0] p8,
  input  logic [DATA_W-1:0] p9,
  input  logic              vld_p0,
  output logic              vld_p1,
  output logic [DATA_W-1:0] pixel_p2,
  output logic              vld_p2
);

  // Sixteen times full scale plus rounding fits in DATA_W+4 unsigned bits;
  // one more bit carries the sign of the laplace/sharpen differences.
  localparam int SUM_W = DATA_W + 5;
  localparam logic signed [SUM_W-1:0] PIX_MAX   = SUM_W'((1 << DATA_W) - 1);
  localparam logic signed [SUM_W-1:0] GAUSS_RND = SUM_W'(8);

  logic signed [SUM_W-1:0] corners, edges, centre, sum_c;
  logic signed [SUM_W-1:0] sum_p1;
  logic [1:0]              mode_p1;
  logic [DATA_W-1:0]       norm_c;

  function automatic logic signed [SUM_W-1:0] ext(input logic [DATA_W-1:0] x);
    return $signed({5'd0, x});
  endfunction

  function automatic logic signed [SUM_W-1:0] abs_s(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] sat_u(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])     return '0;
    else if (v > PIX_MAX) return '1;
    else                return v[DATA_W-1:0];
  endfunction

  // Weighted sum for the selected kernel.
  always_comb begin
    corners = ext(p1) + ext(p3) + ext(p7) + ext(p9);
    edges   = ext(p2) + ext(p4) + ext(p6) + ext(p8);
    centre  = ext(p5);
    case (mode)
      MODE_GAUSS:   sum_c = corners + (edges <<< 1) + (centre <<< 2) + GAUSS_RND;
      MODE_LAPLACE: sum_c = (centre <<< 2) - edges;
      MODE_SHARPEN: sum_c = (centre <<< 2) + centre - edges;
      default:      sum_c = centre;
    endcase
  end

  // ---- stage A boundary ----
  // Sum and its mode travel together; only the valid bit is reset.
  always_ff @(posedge clk) begin
    sum_p1  <= sum_c;
    mode_p1 <= mode;
  end

  // Stage A valid.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // Normalise, rectify or clamp the stage A sum.
  always_comb begin
    case (mode_p1)
      MODE_GAUSS:   norm_c = sum_p1[DATA_W+3:4];
      MODE_LAPLACE: norm_c = sat_u(abs_s(sum_p1));
      MODE_SHARPEN: norm_c = sat_u(sum_p1);
      default:      norm_c = sum_p1[DATA_W-1:0];
    endcase
  end

  // ---- stage B boundary ----
  // Result pixel holds between writes and clears on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      pixel_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) pixel_p2 <= norm_c;
    end
  end

endmodule

// File: rtl/conv3x3_engine.sv
// Frame controller for the 3x3 window engine: strobes one window read per
// cycle for a whole frame, drains the kernel pipeline, then pulses done.
module conv3x3_engine
  import conv3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  input  logic [7:0] p3,
  input  logic [7:0] p4,
  input  logic [7:0] p5,
  input  logic [7:0] p6,
  input  logic [7:0] p7,
  input  logic [7:0] p8,
  input  logic [7:0] p9,
  output logic       rd,
  output logic [7:0] pixelw,
  output logic       wr,
  output logic       busy,
  output logic       done
);

  localparam int FRAME = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(FRAME - 1);

  state_t           state;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       mode_lat;
  logic             vld_p0;
  logic             vld_p1;

  // Frame sequencing with registered rd/busy/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rd_cnt   <= '0;
      rd       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_lat <= MODE_PASS;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_READ;
            rd       <= 1'b1;
            busy     <= 1'b1;
            rd_cnt   <= '0;
            mode_lat <= mode;
          end
        end
        ST_READ: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_RD) begin
            state <= ST_DRAIN;
            rd    <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // The last write is already registered once stage A is empty.
          if (!vld_p0 && !vld_p1) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- window arrival boundary ----
  // Pixels from the buffer are present the cycle after rd.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= rd;
  end

  conv3x3_kernel #(.DATA_W(8)) u_kernel (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode_lat),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .p5       (p5),
    .p6       (p6),
    .p7       (p7),
    .p8       (p8),
    .p9       (p9),
    .vld_p0   (vld_p0),
    .vld_p1   (vld_p1),
    .pixel_p2 (pixelw),
    .vld_p2   (wr)
  );

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine: a buffer model answers each rd with a
// directed window and queues its hand-computed result; a monitor pops and
// compares on every wr.
module tb_conv3x3_engine;
  import conv3x3_pkg::*;

  typedef struct packed {
    logic [1:0]      m;
    logic [8:0][7:0] w;
    logic [7:0]      e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [1:0] mode;
  logic [7:0] pw [0:8];
  logic       rd, wr, busy, done;
  logic [7:0] pixelw;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'd0;
  vec_t vt[0:12];
  int   sel[$];
  int   pos = 0;

  always #5 clk = ~clk;

  conv3x3_engine #(.IMG_W(64), .IMG_H(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .p1     (pw[0]),
    .p2     (pw[1]),
    .p3     (pw[2]),
    .p4     (pw[3]),
    .p5     (pw[4]),
    .p6     (pw[5]),
    .p7     (pw[6]),
    .p8     (pw[7]),
    .p9     (pw[8]),
    .rd     (rd),
    .pixelw (pixelw),
    .wr     (wr),
    .busy   (busy),
    .done   (done)
  );

  function automatic vec_t mk(input logic [1:0] m, input logic [7:0] c,
                              input logic [7:0] ed, input logic [7:0] ctr,
                              input logic [7:0] e);
    vec_t v;
    v.m = m; v.e = e;
    v.w[0] = c;  v.w[2] = c;  v.w[6] = c;  v.w[8] = c;
    v.w[1] = ed; v.w[3] = ed; v.w[5] = ed; v.w[7] = ed;
    v.w[4] = ctr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic set_sel(input logic [1:0] m);
    sel.delete();
    pos = 0;
    for (int i = 0; i <= 12; i++) if (vt[i].m == m) sel.push_back(i);
  endtask

  // Buffer model: answers the rd seen last cycle with the next window.
  initial begin
    logic rd_seen;
    vec_t v;
    forever begin
      @(negedge clk);
      rd_seen = rd;
      @(posedge clk);
      #1;
      if (rd_seen === 1'b1 && sel.size() > 0) begin
        v = vt[sel[pos % sel.size()]];
        for (int i = 0; i < 9; i++) pw[i] = v.w[i];
        exp_q.push_back(v.e);
        pos++;
      end
    end
  end

  // Monitor: every write must match the oldest outstanding expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: write of %0d with nothing expected", pixelw);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          if (pixelw !== e) begin
            errors++;
            $display("FAIL pixel: got %0d expected %0d", pixelw, e);
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [1:0] m, input bit abort);
    int c, first_rd, n_rd, first_wr, n_wr, done_c, n_done;
    set_sel(m);
    first_rd = -1; first_wr = -1; done_c = -1;
    n_rd = 0; n_wr = 0; n_done = 0;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c <= 4130) begin
      if (rd === 1'b1) begin if (first_rd < 0) first_rd = c; n_rd++; end
      if (wr === 1'b1) begin if (first_wr < 0) first_wr = c; n_wr++; end
      if (done === 1'b1) begin if (done_c < 0) done_c = c; n_done++; end
      if (c == 1) chk("busy_rise", busy, 1);
      if (done_c > 0 && c == done_c + 1) chk("busy_fall", busy, 0);
      if (abort && c == 2001) begin
        chk("rd_before_abort", n_rd, 2001);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rd", rd, 0);
        chk("abort_wr", wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pixelw", pixelw, 0);
        rst_n = 1'b1;
        n_wr = 0;
        repeat (10) begin
          @(negedge clk);
          if (wr === 1'b1) n_wr++;
        end
        chk("no_wr_after_rst", n_wr, 0);
        exp_q.delete();
        return;
      end
      // Mode changes and stray starts mid-frame must have no effect.
      if (c == 50) mode = ~m;
      start = (c == 100 || c == 4098);
      @(negedge clk);
      c++;
    end
    chk("first_rd", first_rd, 1);
    chk("rd_count", n_rd, 4096);
    chk("first_wr", first_wr, 4);
    chk("wr_count", n_wr, 4096);
    chk("done_cycle", done_c, 4100);
    chk("done_width", n_done, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("pixelw_hold", pixelw, last_exp);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = MODE_PASS;
    for (int i = 0; i < 9; i++) pw[i] = 8'd0;
    vt[0]  = mk(MODE_PASS,    8'd100, 8'd100, 8'd100, 8'd100);
    vt[1]  = mk(MODE_PASS,    8'd0,   8'd0,   8'd7,   8'd7);
    vt[2]  = mk(MODE_PASS,    8'd3,   8'd200, 8'd42,  8'd42);
    vt[3]  = mk(MODE_GAUSS,   8'd255, 8'd255, 8'd255, 8'd255);
    vt[4]  = mk(MODE_GAUSS,   8'd0,   8'd0,   8'd16,  8'd4);
    vt[5]  = mk(MODE_GAUSS,   8'd0,   8'd10,  8'd0,   8'd5);
    vt[6]  = mk(MODE_GAUSS,   8'd10,  8'd20,  8'd30,  8'd20);
    vt[7]  = mk(MODE_LAPLACE, 8'd0,   8'd255, 8'd0,   8'd255);
    vt[8]  = mk(MODE_LAPLACE, 8'd0,   8'd8,   8'd10,  8'd8);
    vt[9]  = mk(MODE_LAPLACE, 8'd200, 8'd10,  8'd50,  8'd160);
    vt[10] = mk(MODE_SHARPEN, 8'd0,   8'd0,   8'd255, 8'd255);
    vt[11] = mk(MODE_SHARPEN, 8'd0,   8'd200, 8'd0,   8'd0);
    vt[12] = mk(MODE_SHARPEN, 8'd0,   8'd50,  8'd60,  8'd100);

    repeat (3) @(negedge clk);
    chk("reset_rd", rd, 0);
    chk("reset_wr", wr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pixelw", pixelw, 0);
    rst_n = 1'b1;

    run_frame(MODE_PASS, 1'b0);
    run_frame(MODE_GAUSS, 1'b0);
    run_frame(MODE_LAPLACE, 1'b0);
    run_frame(MODE_SHARPEN, 1'b0);
    run_frame(MODE_PASS, 1'b1);
    run_frame(MODE_PASS, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Window-processing engine on the far side of the frame buffer's 3x3 read port. It drives the buffer's read strobe, consumes the nine window pixels the buffer returns, applies a selectable 3x3 kernel in a two-stage pipeline, and writes one result pixel per window back through the buffer's write port. It streams a full 64x64 result frame per `start` and flags completion with `done`.

## Interface
- `IMG_W`, 64: result frame width in pixels; the buffer presents IMG_W windows per row.
- `IMG_H`, 64: result frame height in rows.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to process a frame; honoured only in IDLE.
- `mode`  in  2  kernel select, sampled when `start` is accepted: 00 pass, 01 gauss, 10 laplace, 11 sharpen.
- `p1`..`p9`  in  8 each  window pixels, row-major (p1 top-left, p5 centre, p9 bottom-right); valid the cycle after `rd` is high.
- `rd`  out  1  window read strobe to the buffer.
- `pixelw`  out  8  result pixel.
- `wr`  out  1  result write strobe; `pixelw` is valid while `wr` is high.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last `wr`.

## Operation
- FSM states: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: `rd`=0. `start`=1 latches `mode` and enters READ.
- READ: `rd`=1 for exactly IMG_W*IMG_H consecutive cycles. A 12-bit read counter (0..4095) runs; on the cycle it reads 4095, the FSM moves to DRAIN.
- DRAIN: `rd`=0. Holds until the pipeline valid bits are all clear (3 cycles).
- DONE: `done`=1 for one cycle, `busy`=0 from the next cycle, return to IDLE.
- `start` in any state other than IDLE is ignored. `mode` changes after acceptance have no effect.
- The pipeline valid chain is `rd` delayed 1 cycle (pixels present), 2 cycles (stage A), and 3 cycles (`wr`).
- Kernels (stage A sums, stage B normalise/clamp):
  - pass: p5.
  - gauss: (p1+p3+p7+p9 + 2(p2+p4+p6+p8) + 4p5 + 8) >> 4. This is 12-bit unsigned, with a maximum of 255, so no clamp is needed.
  - laplace: |4p5 − (p2+p4+p6+p8)|. The signed range is 11 bits (−1020..1020); the result is clamped to 255.
  - sharpen: 5p5 − (p2+p4+p6+p8). The signed range is 12 bits (−1020..1275); the result is clamped to 0..255.
- Frame boundaries: the buffer's address counters clear only on `rst_n`. The system controller asserts `rst_n` between frames. The engine itself may accept a new `start` straight after `done`.
- Reset (at any point, including mid-frame):
  - FSM goes to IDLE and the read counter and all valid bits clear.
  - `rd`, `wr`, `busy`, `done` are 0 and `pixelw` is 8'h00 at the next edge.
  - No partial write follows reset.

## Timing
- Reset values: `rd`=0, `wr`=0, `pixelw`=0, `busy`=0, `done`=0.
- `start` is sampled at edge N. `rd` and `busy` rise after edge N.
- Read/write latency: `rd` high in cycle t, pixels valid in t+1, stage A registered at end of t+1, `pixelw`/`wr` registered at end of t+2 and visible in t+3. The rd->wr latency is exactly 3 cycles.
- `wr` is a contiguous 4096-cycle burst, a copy of `rd` delayed by 3 cycles.
- `done` is high in the cycle after the final `wr` cycle.
- Total from `start` edge to `done`: 4096 + 4 cycles.
- `pixelw` holds its last value while `wr`=0.

## Structure
- Package `conv3x3_pkg`:
  - mode encoding constants (MODE_PASS, MODE_GAUSS, MODE_LAPLACE, MODE_SHARPEN);
  - FSM state enum;
  - default IMG_W/IMG_H.
- Sub-module `conv3x3_kernel`:
  - inputs: latched mode, p1..p9, in-valid;
  - two register stages, with the sum in stage A and normalise/abs/clamp in stage B;
  - outputs: 8-bit result and out-valid.
- The top level holds the FSM, the read counter, and the done/busy logic.

## Test plan
- Reset then `start`, mode 00, constant window 8'd100: `rd` high 4096 cycles, `wr` exactly 4096 cycles starting 3 cycles after `rd`, `pixelw`=100, `done` pulse at cycle 4100.
- Gauss, p5=255 and all others 255 -> 255. Gauss, p5=16 and others 0 -> (64+8)>>4 = 4.
- Laplace, p5=0 and neighbours 255 -> 255 (clamped). Laplace, p5=10 with p2=p4=p6=p8=8 -> 8.
- Sharpen, p5=255 and neighbours 0 -> 255 (clamped). Sharpen, p5=0 and neighbours 200 -> 0. Sharpen, p5=60 with neighbours 50 -> 100.
- `start` pulsed during READ and during DRAIN is ignored. Changing `mode` mid-frame leaves all outputs computed with the latched mode.
- `rst_n` low at read cycle 2000: at the next edge `rd`=`wr`=`busy`=`done`=0 and `pixelw`=0. No `wr` follows. A fresh `start` then yields a complete 4096-write frame.
